// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access codes, FSM states
// and small decode helpers for access width, byte enables and alignment.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  // funct3[1:0] carries the width; undefined codes (011/110/111) fall to word.
  function automatic lsu_size_e access_size(input logic [2:0] f3);
    lsu_size_e sz;
    case (f3[1:0])
      2'b00:   sz = SZ_B;
      2'b01:   sz = SZ_H;
      default: sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (access_size(f3))
      SZ_B:    be = 4'b0001 << a;
      SZ_H:    be = 4'b0011 << {a[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    case (access_size(f3))
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = ~a[0];
      default: ok = (a == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Load data formatter: picks the addressed byte/half lane out of the bus word
// and sign- or zero-extends it according to funct3. Purely combinational.
module lsu_load_fmt
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select followed by extension; unknown funct3 passes the word.
  always_comb begin
    byte_v = rdata[{lane, 3'b000} +: 8];
    half_v = lane[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_v[7]}}, byte_v};
      F3_BU:   data = {24'h0, byte_v};
      F3_H:    data = {{16{half_v[15]}}, half_v};
      F3_HU:   data = {16'h0, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the single-cycle core and a req/ack data bus.
// Accepts one aligned access at a time (IDLE -> WAIT -> DONE -> IDLE),
// stalls the core while the bus transfer is outstanding, rejects misaligned
// accesses with a one-cycle misalign pulse.
// Optional feature: define LSU_TIMEOUT_EN to abort a transfer after TMO_CYC
// WAIT cycles without bus_ack (sets sticky bus_err and releases the core).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 15
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] MEM_addr,
  input  logic [DATA_W-1:0] MEM_wDATA,
  output logic [DATA_W-1:0] MEM_rData,
  output logic              stall,
  output logic              misalign,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err
);

  if (DATA_W != 32) begin : g_bad_width
    $error("load_store_unit supports DATA_W == 32 only");
  end
  if (TMO_CYC < 1) begin : g_bad_tmo
    $error("load_store_unit requires TMO_CYC >= 1");
  end

  lsu_state_e        state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       fmt_data;
  logic [31:0]       wdata_lanes;
  logic              access;
  logic              aligned;
  logic              misalign_c;

`ifdef LSU_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             bus_err_q, bus_err_d;
`endif

  lsu_load_fmt u_load_fmt (
    .funct3 (f3_q),
    .lane   (lane_q),
    .rdata  (bus_rdata),
    .data   (fmt_data)
  );

  assign access  = mem_rd | mem_wr;
  assign aligned = is_aligned(funct3, MEM_addr[1:0]);

  // Store data replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    case (access_size(funct3))
      SZ_B:    wdata_lanes = {4{MEM_wDATA[7:0]}};
      SZ_H:    wdata_lanes = {2{MEM_wDATA[15:0]}};
      default: wdata_lanes = MEM_wDATA;
    endcase
  end

  // Next-state, bus latching and stall/misalign decode.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    f3_d        = f3_q;
    lane_d      = lane_q;
    rdata_d     = rdata_q;
    stall       = 1'b0;
    misalign_c  = 1'b0;
`ifdef LSU_TIMEOUT_EN
    tmo_d       = tmo_q;
    bus_err_d   = bus_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (aligned) begin
            stall       = 1'b1;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_wr;
            bus_addr_d  = {MEM_addr[ADDR_W-1:2], 2'b00};
            bus_be_d    = byte_en(funct3, MEM_addr[1:0]);
            bus_wdata_d = wdata_lanes;
            f3_d        = funct3;
            lane_d      = MEM_addr[1:0];
            state_d     = S_WAIT;
`ifdef LSU_TIMEOUT_EN
            tmo_d       = '0;
`endif
          end else begin
            misalign_c = 1'b1;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (bus_ack) begin
          if (!bus_we_q) rdata_d = fmt_data;
          bus_req_d = 1'b0;
          state_d   = S_DONE;
        end
`ifdef LSU_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          rdata_d   = '0;
          state_d   = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and bus registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rest) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      f3_q        <= '0;
      lane_q      <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      f3_q        <= f3_d;
      lane_q      <= lane_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  // Timeout counter and sticky abort flag.
  always_ff @(posedge clk) begin
    if (rest) begin
      tmo_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  // A rejected access reads back zero in its own cycle; the held load value is untouched.
  assign MEM_rData = misalign_c ? '0 : rdata_q;
  assign misalign  = misalign_c;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, sign/zero-extended loads,
// misalignment rejection, reset mid-transfer and (with LSU_TIMEOUT_EN) abort.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rest;
  logic        mem_rd, mem_wr;
  logic [2:0]  funct3;
  logic [7:0]  MEM_addr;
  logic [31:0] MEM_wDATA;
  logic [31:0] MEM_rData;
  logic        stall, misalign;
  logic        bus_req, bus_we;
  logic [7:0]  bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  int n_cmp = 0;
  int n_err = 0;

  load_store_unit #(.ADDR_W(8), .DATA_W(32), .TMO_CYC(15)) dut (
    .clk       (clk),
    .rest      (rest),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .funct3    (funct3),
    .MEM_addr  (MEM_addr),
    .MEM_wDATA (MEM_wDATA),
    .MEM_rData (MEM_rData),
    .stall     (stall),
    .misalign  (misalign),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [7:0] addr, input logic [31:0] wd);
    mem_rd    = rd;
    mem_wr    = wr;
    funct3    = f3;
    MEM_addr  = addr;
    MEM_wDATA = wd;
  endtask

  // One access acked in the first WAIT cycle; checks bus fields and the result.
  task automatic xfer(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [7:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                      input logic [3:0] exp_be, input logic [7:0] exp_addr,
                      input logic [31:0] exp_wd, input logic [31:0] exp_rd);
    drive(rd, wr, f3, addr, wd);
    #1;
    check({tag, ".stall_idle"}, 32'(stall), 32'd1);
    tick;
    check({tag, ".req"}, 32'(bus_req), 32'd1);
    check({tag, ".we"}, 32'(bus_we), 32'(wr));
    check({tag, ".be"}, 32'(bus_be), 32'(exp_be));
    check({tag, ".addr"}, 32'(bus_addr), 32'(exp_addr));
    check({tag, ".wdata"}, bus_wdata, exp_wd);
    bus_ack   = 1'b1;
    bus_rdata = rdata;
    tick;
    bus_ack = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
    check({tag, ".stall_done"}, 32'(stall), 32'd0);
    check({tag, ".req_done"}, 32'(bus_req), 32'd0);
    check({tag, ".rdata"}, MEM_rData, exp_rd);
    tick;
  endtask

  initial begin
    rest = 1'b1;
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    drive(1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
    tick;
    tick;
    rest = 1'b0;
    #1;
    check("rst.req", 32'(bus_req), 32'd0);
    check("rst.we", 32'(bus_we), 32'd0);
    check("rst.be", 32'(bus_be), 32'd0);
    check("rst.addr", 32'(bus_addr), 32'd0);
    check("rst.wdata", bus_wdata, 32'h0);
    check("rst.rdata", MEM_rData, 32'h0);
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.misalign", 32'(misalign), 32'd0);
    check("rst.err", 32'(bus_err), 32'd0);

    // SW 0x10, ack after two WAIT cycles: stall high for three cycles.
    drive(1'b0, 1'b1, 3'b010, 8'h10, 32'hCAFEBABE);
    #1;
    check("sw.stall1", 32'(stall), 32'd1);
    tick;
    check("sw.stall2", 32'(stall), 32'd1);
    check("sw.req", 32'(bus_req), 32'd1);
    check("sw.we", 32'(bus_we), 32'd1);
    check("sw.be", 32'(bus_be), 32'hF);
    check("sw.addr", 32'(bus_addr), 32'h10);
    check("sw.wdata", bus_wdata, 32'hCAFEBABE);
    tick;
    check("sw.stall3", 32'(stall), 32'd1);
    check("sw.req_hold", 32'(bus_req), 32'd1);
    bus_ack = 1'b1;
    tick;
    bus_ack = 1'b0;
    check("sw.done_stall", 32'(stall), 32'd0);
    check("sw.done_req", 32'(bus_req), 32'd0);
    check("sw.rdata_kept", MEM_rData, 32'h0);
    drive(1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
    tick;
    check("sw.idle_stall", 32'(stall), 32'd0);

    // Byte store/load on lane 3.
    xfer("sb13", 1'b0, 1'b1, 3'b000, 8'h13, 32'h000000A5, 32'h0,
         4'b1000, 8'h10, 32'hA5A5A5A5, 32'h0);
    xfer("lb13", 1'b1, 1'b0, 3'b000, 8'h13, 32'h0, 32'hA5000000,
         4'b1000, 8'h10, 32'h0, 32'hFFFFFFA5);
    xfer("lbu11", 1'b1, 1'b0, 3'b100, 8'h11, 32'h0, 32'h00008000,
         4'b0010, 8'h10, 32'h0, 32'h00000080);

    // Upper halfword, zero and sign extended.
    xfer("lhu22", 1'b1, 1'b0, 3'b101, 8'h22, 32'h0, 32'h80011234,
         4'b1100, 8'h20, 32'h0, 32'h00008001);
    xfer("lh22", 1'b1, 1'b0, 3'b001, 8'h22, 32'h0, 32'h80011234,
         4'b1100, 8'h20, 32'h0, 32'hFFFF8001);

    // Halfword store leaves the held load value unchanged.
    xfer("sh06", 1'b0, 1'b1, 3'b001, 8'h06, 32'h1234BEEF, 32'h0,
         4'b1100, 8'h04, 32'hBEEFBEEF, 32'hFFFF8001);

    // Misaligned word load.
    drive(1'b1, 1'b0, 3'b010, 8'h05, 32'h0);
    #1;
    check("lw05.misalign", 32'(misalign), 32'd1);
    check("lw05.stall", 32'(stall), 32'd0);
    check("lw05.rdata", MEM_rData, 32'h0);
    tick;
    check("lw05.req", 32'(bus_req), 32'd0);
    // Misaligned halfword store.
    drive(1'b0, 1'b1, 3'b001, 8'h21, 32'h1111);
    #1;
    check("sh21.misalign", 32'(misalign), 32'd1);
    check("sh21.stall", 32'(stall), 32'd0);
    tick;
    check("sh21.req", 32'(bus_req), 32'd0);
    drive(1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
    #1;
    check("idle.misalign", 32'(misalign), 32'd0);
    tick;

    // Word load and undefined funct3 (treated as word, no extension).
    xfer("lw30", 1'b1, 1'b0, 3'b010, 8'h30, 32'h0, 32'h89ABCDEF,
         4'b1111, 8'h30, 32'h0, 32'h89ABCDEF);
    xfer("f3_110", 1'b1, 1'b0, 3'b110, 8'h34, 32'h0, 32'h80000001,
         4'b1111, 8'h34, 32'h0, 32'h80000001);

    // Reset while waiting; the late ack must be ignored.
    drive(1'b1, 1'b0, 3'b010, 8'h40, 32'h0);
    tick;
    check("rstw.req", 32'(bus_req), 32'd1);
    rest = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
    tick;
    rest = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 32'hFFFFFFFF;
    check("rstw.req_after", 32'(bus_req), 32'd0);
    check("rstw.rdata", MEM_rData, 32'h0);
    check("rstw.stall", 32'(stall), 32'd0);
    tick;
    bus_ack = 1'b0;
    check("rstw.late_req", 32'(bus_req), 32'd0);
    check("rstw.late_rdata", MEM_rData, 32'h0);
    check("rstw.late_stall", 32'(stall), 32'd0);

`ifdef LSU_TIMEOUT_EN
    // No ack: abort after 15 WAIT cycles, bus_err sticky until reset.
    drive(1'b1, 1'b0, 3'b010, 8'h50, 32'h0);
    tick;
    for (int i = 1; i < 15; i++) begin
      check("tmo.stall_wait", 32'(stall), 32'd1);
      check("tmo.err_wait", 32'(bus_err), 32'd0);
      tick;
    end
    check("tmo.stall_last", 32'(stall), 32'd1);
    tick;
    check("tmo.err", 32'(bus_err), 32'd1);
    check("tmo.stall", 32'(stall), 32'd0);
    check("tmo.req", 32'(bus_req), 32'd0);
    check("tmo.rdata", MEM_rData, 32'h0);
    drive(1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
    tick;
    tick;
    check("tmo.err_sticky", 32'(bus_err), 32'd1);
    rest = 1'b1;
    tick;
    rest = 1'b0;
    check("tmo.err_clr", 32'(bus_err), 32'd0);
`else
    // Without the timeout the transfer simply waits.
    drive(1'b1, 1'b0, 3'b010, 8'h50, 32'h0);
    tick;
    for (int i = 0; i < 20; i++) tick;
    check("notmo.stall", 32'(stall), 32'd1);
    check("notmo.req", 32'(bus_req), 32'd1);
    check("notmo.err", 32'(bus_err), 32'd0);
    bus_ack = 1'b1;
    bus_rdata = 32'h13579BDF;
    tick;
    bus_ack = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 8'h00, 32'h0);
    check("notmo.rdata", MEM_rData, 32'h13579BDF);
    tick;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
